data_ram_arbiter: RTL

- Shares the single-port DATA_RAM between CORE_COUNT processor cores with round-robin arbitration, one access per cycle.
- Returns read data to the requesting core, tagged one cycle after grant, matching the RAM's registered-address read path.
- Sequences end-of-run: when every core reports done and no read is in flight, raises processDone to the RAM.
- Sits between the core array and DATA_RAM in the multicore top level.

---
 rtl/data_ram_arbiter_pkg.sv | 17 +
 rtl/data_ram_arbiter_rr_priority_picker.sv | 32 +++
 rtl/data_ram_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/data_ram_arbiter_pkg.sv
// Shared types for the DATA_RAM sharing logic: arbiter sequencing states and
// the RAM initialisation selector used by the multicore top level.
package data_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_INIT_NONE,
    MEM_INIT_ZERO,
    MEM_INIT_FILE
  } mem_init_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } arb_state_t;

endpackage

// File: rtl/data_ram_arbiter_rr_priority_picker.sv
// Round-robin picker: first requester after last_gnt, wrapping modulo CORE_COUNT.
// Purely combinational; no state, so it can be shared by any memory-sharing arbiter.
module rr_priority_picker #(
  parameter int CORE_COUNT = 4,
  parameter int ID_WIDTH   = $clog2(CORE_COUNT)
) (
  input  logic [CORE_COUNT-1:0] req,
  input  logic [ID_WIDTH-1:0]   last_gnt,
  output logic [CORE_COUNT-1:0] gnt,
  output logic [ID_WIDTH-1:0]   winner,
  output logic                  any_gnt
);

  logic [ID_WIDTH-1:0] idx;

  always_comb begin
    gnt     = '0;
    winner  = '0;
    any_gnt = 1'b0;
    idx     = '0;
    // last_gnt itself is scanned last, so a lone requester still wins every cycle
    for (int i = 1; i <= CORE_COUNT; i++) begin
      idx = ID_WIDTH'((int'(last_gnt) + i) % CORE_COUNT);
      if (!any_gnt && req[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        winner   = idx;
      end
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Round-robin sharing of single-port DATA_RAM between cores; reads return one cycle
// after grant, and processDone is raised once all cores finish and no read is in flight.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int CORE_COUNT = 4,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ID_WIDTH   = $clog2(CORE_COUNT)
) (
  input  logic                                  clk,
  input  logic                                  rstN,
  input  logic [CORE_COUNT-1:0]                 req,
  input  logic [CORE_COUNT-1:0]                 reqWrEn,
  input  logic [CORE_COUNT-1:0][ADDR_WIDTH-1:0] reqAddr,
  input  logic [CORE_COUNT-1:0][WIDTH-1:0]      reqDataIn,
  input  logic [CORE_COUNT-1:0]                 coreDone,
  output logic [CORE_COUNT-1:0]                 gnt,
  output logic [CORE_COUNT-1:0]                 rdValid,
  output logic [WIDTH-1:0]                      rdData,
  output logic                                  ramWrEn,
  output logic [ADDR_WIDTH-1:0]                 ramAddr,
  output logic [WIDTH-1:0]                      ramDataIn,
  input  logic [WIDTH-1:0]                      ramDataOut,
  output logic                                  processDone
);

  arb_state_t                state_q;
  logic                      process_done_q;
  logic [ID_WIDTH-1:0]       last_gnt_q, last_gnt_d;
  logic                      tag_vld_q, tag_vld_d;
  logic [ID_WIDTH-1:0]       tag_id_q, tag_id_d;
  logic [ADDR_WIDTH-1:0]     addr_hold_q, addr_hold_d;

  logic [CORE_COUNT-1:0]     pick_gnt;
  logic [ID_WIDTH-1:0]       winner;
  logic                      pick_any;
  logic                      grant_ok;
  logic                      any_gnt;

  rr_priority_picker #(
    .CORE_COUNT (CORE_COUNT),
    .ID_WIDTH   (ID_WIDTH)
  ) u_picker (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (pick_gnt),
    .winner   (winner),
    .any_gnt  (pick_any)
  );

  // Grants are suppressed while reset is held so nothing reaches the RAM port.
  assign grant_ok = (state_q == RUN) && rstN;
  assign any_gnt  = pick_any && grant_ok;

  always_comb begin
    gnt         = grant_ok ? pick_gnt : '0;
    ramWrEn     = reqWrEn[winner] & any_gnt;
    ramAddr     = any_gnt ? reqAddr[winner] : addr_hold_q;
    ramDataIn   = reqDataIn[winner];
    addr_hold_d = ramAddr;
    last_gnt_d  = any_gnt ? winner : last_gnt_q;
    tag_vld_d   = any_gnt & ~reqWrEn[winner];
    tag_id_d    = any_gnt ? winner : tag_id_q;
    rdValid     = tag_vld_q ? (CORE_COUNT'(1) << tag_id_q) : '0;
    rdData      = ramDataOut;
  end

  assign processDone = process_done_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      last_gnt_q  <= ID_WIDTH'(CORE_COUNT - 1);
      tag_vld_q   <= 1'b0;
      tag_id_q    <= '0;
      addr_hold_q <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q        <= RUN;
      process_done_q <= 1'b0;
    end else begin
      case (state_q)
        RUN:   if (&coreDone) state_q <= DRAIN;
        DRAIN: begin
          if (!tag_vld_q) begin
            state_q        <= DONE;
            process_done_q <= 1'b1;
          end
        end
        DONE:    process_done_q <= 1'b1;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule
